// File: rtl/ram_pipe_if.sv
// ram_pipe_if: request/response bus of the pipelined single-port RAM.
//   A        address width
//   D        data width (multiple of 8)
//   Signals:
//     cs       request strobe
//     write    1 = write, 0 = read (qualified by cs)
//     be       byte-lane write enables, bit i covers data[8i+7:8i]
//     addr     word address
//     data_in  write data
//     ready    requests are accepted while high
//     rvalid   one-cycle pulse marking data_out valid for a read
//     data_out read data, held between reads
//   master modport: requester side; slave modport: RAM side.
interface ram_pipe_if #(
  parameter int unsigned A = 10,
  parameter int unsigned D = 16
);
  logic             cs;
  logic             write;
  logic [D/8-1:0]   be;
  logic [A-1:0]     addr;
  logic [D-1:0]     data_in;
  logic             ready;
  logic             rvalid;
  logic [D-1:0]     data_out;

  modport master (
    output cs, write, be, addr, data_in,
    input  ready, rvalid, data_out
  );

  modport slave (
    input  cs, write, be, addr, data_in,
    output ready, rvalid, data_out
  );
endinterface

// File: rtl/ram_pipe.sv
// ram_pipe: single-port RAM with byte-lane writes, a 1- or 2-cycle read
// pipeline and an optional zero-fill sweep after reset.
//   Parameters:
//     A      address width, depth is 2^A words
//     D      data width, multiple of 8, minimum 8
//     LAT    read latency in cycles (1 or 2)
//     CLEAR  1 = zero-fill memory after reset, 0 = skip the fill
//   Ports:
//     clk    single rising-edge clock
//     reset  synchronous, active-high reset
//     bus    ram_pipe_if slave modport (cs/write/be/addr/data_in in,
//            ready/rvalid/data_out out)
module ram_pipe #(
  parameter int unsigned A     = 10,
  parameter int unsigned D     = 16,
  parameter int unsigned LAT   = 1,
  parameter int unsigned CLEAR = 1
) (
  input  logic      clk,
  input  logic      reset,
  ram_pipe_if.slave bus
);

  localparam int unsigned NB    = D / 8;
  localparam int unsigned DEPTH = 1 << A;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [A-1:0]   cnt_q;
  logic           ready_q;

  logic           fill_we;
  logic           acc_wr;
  logic           acc_rd;

  logic [D-1:0]   mem [DEPTH];

  logic           rvalid_q;
  logic [D-1:0]   dout_q;

  // Next state and request qualification. Nothing is written or accepted
  // on a reset edge so reset never touches memory contents.
  always_comb begin
    state_d = state_q;
    fill_we = 1'b0;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    if (!reset) begin
      case (state_q)
        CLR: begin
          fill_we = 1'b1;
          if (cnt_q == '1) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.cs && ready_q) begin
            acc_wr = bus.write;
            acc_rd = !bus.write;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ready follows the next state so it rises on the same edge that
  // completes the last fill write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR != 0) ? CLR : RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_we) begin
        cnt_q <= cnt_q + 1'b1;
      end
      ready_q <= (state_d == RUN);
    end
  end

  // Memory array: fill sweep or byte-lane write, never both in a cycle.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[cnt_q] <= '0;
    end else if (acc_wr) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.be[i]) begin
          mem[bus.addr][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline. The word is sampled at the accepting edge; the output
  // register only loads on a matured read so data_out holds otherwise.
  generate
    if (LAT == 2) begin : g_lat2
      logic         v1_q;
      logic [D-1:0] d1_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          v1_q     <= 1'b0;
          d1_q     <= '0;
          rvalid_q <= 1'b0;
          dout_q   <= '0;
        end else begin
          v1_q <= acc_rd;
          if (acc_rd) begin
            d1_q <= mem[bus.addr];
          end
          rvalid_q <= v1_q;
          if (v1_q) begin
            dout_q <= d1_q;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid_q <= 1'b0;
          dout_q   <= '0;
        end else begin
          rvalid_q <= acc_rd;
          if (acc_rd) begin
            dout_q <= mem[bus.addr];
          end
        end
      end
    end
  endgenerate

  assign bus.ready    = ready_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_ram_pipe.sv
// tb_ram_pipe: directed self-checking bench for ram_pipe.
// Three instances share one stimulus stream:
//   u1: A=4 D=16 LAT=1 CLEAR=1
//   u2: A=4 D=16 LAT=2 CLEAR=1
//   u3: A=4 D=16 LAT=1 CLEAR=0 (its cs is gated until the others finish filling)
module tb_ram_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        write;
  logic [1:0]  be;
  logic [3:0]  addr;
  logic [15:0] din;
  logic        en3;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  ram_pipe_if #(.A(4), .D(16)) bus1 ();
  ram_pipe_if #(.A(4), .D(16)) bus2 ();
  ram_pipe_if #(.A(4), .D(16)) bus3 ();

  assign bus1.cs = cs;       assign bus2.cs = cs;       assign bus3.cs = cs & en3;
  assign bus1.write = write; assign bus2.write = write; assign bus3.write = write;
  assign bus1.be = be;       assign bus2.be = be;       assign bus3.be = be;
  assign bus1.addr = addr;   assign bus2.addr = addr;   assign bus3.addr = addr;
  assign bus1.data_in = din; assign bus2.data_in = din; assign bus3.data_in = din;

  ram_pipe #(.A(4), .D(16), .LAT(1), .CLEAR(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  ram_pipe #(.A(4), .D(16), .LAT(2), .CLEAR(1)) u2 (.clk(clk), .reset(reset), .bus(bus2));
  ram_pipe #(.A(4), .D(16), .LAT(1), .CLEAR(0)) u3 (.clk(clk), .reset(reset), .bus(bus3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    cs = 1'b1; write = 1'b1; addr = a; din = d; be = b;
    tick();
  endtask

  task automatic do_rd(input logic [3:0] a);
    cs = 1'b1; write = 1'b0; addr = a;
    tick();
  endtask

  task automatic idle();
    cs = 1'b0;
    tick();
  endtask

  // Edges until u1 reports ready, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus1.ready && cnt < 40);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cs = 1'b0; write = 1'b0; be = 2'b00; addr = '0; din = '0; en3 = 1'b0;
    repeat (3) tick();
    check("rst_ready1", bus1.ready, 1'b0);
    check("rst_rvalid1", bus1.rvalid, 1'b0);
    check("rst_dout1", bus1.data_out, 16'h0000);
    check("rst_ready3", bus3.ready, 1'b0);
    check("rst_dout2", bus2.data_out, 16'h0000);

    // Release with a blocked write to addr 5 held through the whole fill.
    cs = 1'b1; write = 1'b1; be = 2'b11; addr = 4'd5; din = 16'hFFFF;
    reset = 1'b0;
    tick();
    check("noclr_ready3", bus3.ready, 1'b1);
    check("fill_ready1_e1", bus1.ready, 1'b0);
    wait_ready(n);
    check("fill_len", n + 1, 16);
    check("fill_ready2", bus2.ready, 1'b1);
    cs = 1'b0;
    en3 = 1'b1;

    for (int a = 0; a < 16; a++) begin
      do_rd(4'(a));
      check("fill_rv", bus1.rvalid, 1'b1);
      check("fill_rd", bus1.data_out, 16'h0000);
    end
    idle();
    check("idle_rv1", bus1.rvalid, 1'b0);

    // Byte enables
    do_wr(4'd3, 16'hABCD, 2'b11);
    do_wr(4'd3, 16'h1234, 2'b01);
    do_rd(4'd3);
    check("be_rv1", bus1.rvalid, 1'b1);
    check("be_d1", bus1.data_out, 16'hAB34);
    check("be_d3", bus3.data_out, 16'hAB34);
    check("be_rv2_early", bus2.rvalid, 1'b0);
    idle();
    check("be_rv2", bus2.rvalid, 1'b1);
    check("be_d2", bus2.data_out, 16'hAB34);
    check("be_rv1_off", bus1.rvalid, 1'b0);
    check("be_d1_hold", bus1.data_out, 16'hAB34);

    // LAT=2 latency, read right after write to the same address
    do_wr(4'd7, 16'h5555, 2'b11);
    do_rd(4'd7);
    check("lat_rv2_n", bus2.rvalid, 1'b0);
    check("lat_d2_n", bus2.data_out, 16'hAB34);
    idle();
    check("lat_rv2_n1", bus2.rvalid, 1'b1);
    check("lat_d2_n1", bus2.data_out, 16'h5555);
    idle();
    check("lat_rv2_n2", bus2.rvalid, 1'b0);
    check("lat_d2_n2", bus2.data_out, 16'h5555);

    // Streaming
    do_wr(4'd1, 16'h0011, 2'b11);
    do_wr(4'd2, 16'h0022, 2'b11);
    do_wr(4'd3, 16'h0033, 2'b11);
    do_rd(4'd1);
    check("str_rv1_a", bus1.rvalid, 1'b1);
    check("str_d1_a", bus1.data_out, 16'h0011);
    do_rd(4'd2);
    check("str_rv1_b", bus1.rvalid, 1'b1);
    check("str_d1_b", bus1.data_out, 16'h0022);
    check("str_rv2_a", bus2.rvalid, 1'b1);
    check("str_d2_a", bus2.data_out, 16'h0011);
    do_rd(4'd3);
    check("str_rv1_c", bus1.rvalid, 1'b1);
    check("str_d1_c", bus1.data_out, 16'h0033);
    check("str_d2_b", bus2.data_out, 16'h0022);
    idle();
    check("str_rv1_end", bus1.rvalid, 1'b0);
    check("str_d1_hold", bus1.data_out, 16'h0033);
    check("str_rv2_c", bus2.rvalid, 1'b1);
    check("str_d2_c", bus2.data_out, 16'h0033);
    idle();
    check("str_rv2_end", bus2.rvalid, 1'b0);

    // be=0 write changes nothing; be is ignored on the following read
    do_wr(4'd2, 16'hFFFF, 2'b00);
    do_rd(4'd2);
    check("be0_d1", bus1.data_out, 16'h0022);

    // Reset with a LAT=2 read in flight
    do_rd(4'd7);
    cs = 1'b0;
    reset = 1'b1;
    tick();
    check("rstfl_rv2", bus2.rvalid, 1'b0);
    check("rstfl_d2", bus2.data_out, 16'h0000);
    check("rstfl_ready1", bus1.ready, 1'b0);
    check("rstfl_d1", bus1.data_out, 16'h0000);
    tick();
    check("rstfl_rv2_after", bus2.rvalid, 1'b0);

    // Reset at fill cycle 9 restarts the full sweep
    reset = 1'b0;
    repeat (9) tick();
    check("mid_ready1", bus1.ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n);
    check("refill_len", n, 16);
    check("refill_ready3", bus3.ready, 1'b1);
    do_rd(4'd7);
    check("refill_d1", bus1.data_out, 16'h0000);
    check("noclr_keep_d3", bus3.data_out, 16'h5555);
    idle();
    check("refill_d2", bus2.data_out, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
